scan_decoder: RTL

- Registered, parametrised N:2^N one-hot decoder with an added automatic scan mode.
- Direct mode: a loaded binary index drives exactly one active output line.
- Scan mode: the active line steps through 0..scan_last, holding each index for a programmable dwell, and flags each wrap.
- Used for display-digit multiplexing and chip-select sequencing.

---
 rtl/scan_decoder.sv | 114 +++++++++++
 1 files changed

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
//   Registered N:2^N one-hot decoder with an automatic scan mode.
//   DIRECT: a loaded binary index selects exactly one active output line.
//   SCAN  : the active line steps 0..scan_last, holding each index for
//           dwell+1 cycles, and pulses wrap when it returns to 0.
//   IDLE  : (en=0) all output lines inactive, idx holds.
//
// Parameters
//   N       index width; y is 2**N bits wide
//   DWELL_W width of the dwell input and the internal dwell counter
//   OUT_POL 0 = active-high one-hot, 1 = active-low one-cold
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   en         block enable (0 forces IDLE)
//   mode       0 = DIRECT, 1 = SCAN
//   a          DIRECT index, captured on mode entry or when load=1
//   load       DIRECT capture strobe (ignored in SCAN/IDLE)
//   dwell      extra hold cycles per SCAN index
//   scan_last  last index of the scan range
//   y          registered decode of idx (inactive in IDLE)
//   idx        registered current index
//   wrap       one-cycle pulse on the scan_last -> 0 step
// -----------------------------------------------------------------------------
module scan_decoder #(
    parameter int N       = 3,
    parameter int DWELL_W = 8,
    parameter bit OUT_POL = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               mode,
    input  logic [N-1:0]       a,
    input  logic               load,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [N-1:0]       scan_last,
    output logic [2**N-1:0]    y,
    output logic [N-1:0]       idx,
    output logic               wrap
);

    localparam int W = 2**N;
    localparam logic [W-1:0] INACTIVE = OUT_POL ? {W{1'b1}} : {W{1'b0}};
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t             state, state_nx;
    logic [N-1:0]       idx_nx;
    logic [DWELL_W-1:0] cnt, cnt_nx;
    logic               wrap_nx;
    logic [W-1:0]       y_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            wrap  <= 1'b0;
            y     <= INACTIVE;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
            wrap  <= wrap_nx;
            y     <= y_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        wrap_nx  = 1'b0;

        if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (!mode) begin
            // The dwell counter has no meaning in DIRECT; keep it cleared.
            cnt_nx = '0;
            if (state != DIRECT) begin
                state_nx = DIRECT;
                idx_nx   = a;
            end else if (load) begin
                idx_nx = a;
            end
        end else if (state != SCAN) begin
            state_nx = SCAN;
            idx_nx   = '0;
            cnt_nx   = '0;
        end else if (cnt >= dwell) begin
            // >= rather than == so a dwell lowered below cnt steps at once
            // and a scan_last lowered below idx wraps on the next step.
            cnt_nx = '0;
            if (idx >= scan_last) begin
                idx_nx  = '0;
                wrap_nx = 1'b1;
            end else begin
                idx_nx = idx + 1'b1;
            end
        end else begin
            cnt_nx = cnt + 1'b1;
        end

        // Decode from the next-state values so y, idx and wrap land together.
        if (state_nx == IDLE) y_nx = INACTIVE;
        else                  y_nx = (ONE << idx_nx) ^ INACTIVE;
    end

endmodule
